sd_framer_tx: RTL and testbench

Serial frame transmitter for the 1011 sequence-detector link. Accepts a parallel payload word over a valid/ready handshake. Emits it on a one-bit line as the 4-bit preamble 1011 followed by the payload, MSB first. Inserts stuffed 0 bits so that 1011 never appears on the line except as a preamble. Sits at the transmit end of the link that the 1011 Mealy detector monitors.

---
 rtl/sd_pkg.sv | 19 +
 rtl/sd_stuff_track.sv | 32 +++
 rtl/sd_framer_tx.sv | 126 ++++++++++++
 tb/tb_sd_framer_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants for the 1011 framed serial link: FSM state codes and line patterns.
// No logic; constants only.
// No flow control.
package sd_pkg;

  // FSM state codes (also exported on state_out for debug)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRE   = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STUFF = 2'd3;

  // Frame delimiter sent MSB first, and its length in bits
  localparam logic [3:0] PREAMBLE = 4'b1011;
  localparam int         PRE_LEN  = 4;

  // Three-bit line history that would become 1011 if the next bit were a 1
  localparam logic [2:0] STUFF_PAT = 3'b101;

endpackage

// File: rtl/sd_stuff_track.sv
// Tracks the last three line bits and flags when the bit being sent completes 101.
// stuff_req is combinational on the incoming bit; history updates on the same edge.
// No flow control; clr/shift are driven by the framer FSM.
module sd_stuff_track
  import sd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift,
  input  logic bit_in,
  output logic stuff_req
);

  logic [2:0] hist;
  logic [2:0] hist_nxt;

  assign hist_nxt  = {hist[1:0], bit_in};
  assign stuff_req = (hist_nxt == STUFF_PAT);

  // History register: cleared at frame start, shifted by every bit placed on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 3'b000;
    end else if (clr) begin
      hist <= 3'b000;
    end else if (shift) begin
      hist <= hist_nxt;
    end
  end

endmodule

// File: rtl/sd_framer_tx.sv
// Serial 1011-preamble framer with optional zero-stuffing (SD_FRAMER_TX_STUFF_EN).
// First preamble bit is on seq_out at the accept edge; one line bit per cycle after.
// din_ready high only while idle; din_valid ignored during a frame.
module sd_framer_tx
  import sd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              seq_out,
  output logic              busy,
  output logic [1:0]        state_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;     // preamble bits sent while in PRE, payload bits sent while in DATA
  logic              all_sent;
  logic              pre_bit;
  logic              trk_clr;
  logic              trk_shift;
  logic              trk_bit;
  logic              stuff_req;
  logic              stuff_go;

  assign all_sent  = (cnt == CNT_W'(DATA_W));
  assign pre_bit   = PREAMBLE[2'(PRE_LEN - 1) - cnt[1:0]];
  assign busy      = (state != IDLE);
  assign din_ready = ~busy;
  assign state_out = state;
  assign trk_clr   = (state == IDLE) && din_valid;

  // Bit currently being placed on the line, as seen by the history tracker
  always_comb begin
    trk_bit = 1'b0;
    case (state)
      PRE:     trk_bit = pre_bit;
      DATA:    trk_bit = sreg[DATA_W-1];
      default: trk_bit = 1'b0;
    endcase
  end

`ifdef SD_FRAMER_TX_STUFF_EN
  assign trk_shift = (state == PRE) || (state == STUFF) || ((state == DATA) && !all_sent);
  assign stuff_go  = stuff_req;
`else
  // Without stuffing the tracker is held frozen and its request never consulted
  logic unused_stuff_req;
  assign trk_shift        = 1'b0;
  assign stuff_go         = 1'b0;
  assign unused_stuff_req = stuff_req;
`endif

  sd_stuff_track u_track (
    .clk       (clk),
    .rst       (rst),
    .clr       (trk_clr),
    .shift     (trk_shift),
    .bit_in    (trk_bit),
    .stuff_req (stuff_req)
  );

  // Framer FSM: preamble, MSB-first payload, optional stuffed zeros, then a closing idle bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      seq_out <= 1'b0;
      sreg    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          seq_out <= 1'b0;
          if (din_valid) begin
            sreg    <= din;
            seq_out <= PREAMBLE[PRE_LEN-1];
            cnt     <= CNT_W'(1);
            state   <= PRE;
          end
        end
        PRE: begin
          seq_out <= pre_bit;
          if (cnt == CNT_W'(PRE_LEN - 1)) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (all_sent) begin
            // Return the line to its idle level on the edge that leaves the frame
            seq_out <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            seq_out <= sreg[DATA_W-1];
            sreg    <= {sreg[DATA_W-2:0], 1'b0};
            cnt     <= cnt + 1'b1;
            if (stuff_go) begin
              state <= STUFF;
            end
          end
        end
`ifdef SD_FRAMER_TX_STUFF_EN
        STUFF: begin
          // Stuffed zero; DATA closes the frame if the payload is already exhausted
          seq_out <= 1'b0;
          state   <= DATA;
        end
`endif
        default: begin
          seq_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_framer_tx.sv
module tb_sd_framer_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       seq_out;
  logic       busy;
  logic [1:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  sd_framer_tx #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .seq_out   (seq_out),
    .busy      (busy),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  // Reference frame: preamble, payload MSB first, and (when enabled) a 0 after any bit
  // that leaves 1,0,1 as the last three line bits. line[i] is the i-th bit on the wire.
  function automatic int model(input logic [7:0] d, output bit [63:0] line);
    int  n;
    bit [3:0] pre;
    pre  = 4'b1011;
    line = '0;
    n    = 0;
    for (int i = 3; i >= 0; i--) begin
      line[n] = pre[i];
      n++;
    end
    for (int i = 7; i >= 0; i--) begin
      line[n] = d[i];
      n++;
`ifdef SD_FRAMER_TX_STUFF_EN
      if (line[n-3] && !line[n-2] && line[n-1]) begin
        line[n] = 1'b0;
        n++;
      end
`endif
    end
    return n;
  endfunction

  // Overlapping 1011 detector: bit i set when bits i-3..i on the line read 1,0,1,1
  function automatic bit [63:0] det_mask(input bit [63:0] line, input int len);
    bit [63:0] m;
    m = '0;
    for (int i = 3; i < len; i++)
      if (line[i-3] && !line[i-2] && line[i-1] && line[i]) m[i] = 1'b1;
    return m;
  endfunction

  // Send one word and record the line while busy; checks against the reference model
  task automatic send_frame(input logic [7:0] d, input string name, output int n_got);
    bit [63:0] got, exp;
    int        n, elen;
    got = '0;
    n   = 0;
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    n_cmp++;
    if (state_out !== 2'd1) begin
      n_bad++;
      $display("FAIL %s state_after_accept got=%0d want=1", name, state_out);
    end
    while (busy === 1'b1 && n < 40) begin
      got[n] = seq_out;
      n++;
      @(posedge clk); #1;
    end
    elen  = model(d, exp);
    n_got = n;
    n_cmp++;
    if (n != elen) begin
      n_bad++;
      $display("FAIL %s length got=%0d want=%0d", name, n, elen);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s bits got=%h want=%h", name, got, exp);
    end
    n_cmp++;
    if (seq_out !== 1'b0 || din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s idle_after got seq_out=%b din_ready=%b want 0/1", name, seq_out, din_ready);
    end
`ifdef SD_FRAMER_TX_STUFF_EN
    n_cmp++;
    if (det_mask(got, n) !== 64'h8) begin
      n_bad++;
      $display("FAIL %s detector got=%h want=%h", name, det_mask(got, n), 64'h8);
    end
`endif
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    din_valid = 1'b1;
    din       = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (seq_out !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0 || state_out !== 2'd0) begin
      n_bad++;
      $display("FAIL reset got seq_out=%b din_ready=%b busy=%b state=%0d want 0/1/0/0",
               seq_out, din_ready, busy, state_out);
    end
    @(negedge clk);
    din_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed();
    int n;
    logic [7:0] words [4];
    int         lens  [4];
    words = '{8'h00, 8'hAA, 8'h05, 8'h60};
`ifdef SD_FRAMER_TX_STUFF_EN
    lens  = '{12, 14, 13, 14};
`else
    lens  = '{12, 12, 12, 12};
`endif
    for (int i = 0; i < 4; i++) begin
      send_frame(words[i], $sformatf("fixed_%h", words[i]), n);
      n_cmp++;
      if (n != lens[i]) begin
        n_bad++;
        $display("FAIL fixed_len_%h got=%0d want=%0d", words[i], n, lens[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_frame(8'($urandom), $sformatf("rand_%0d", k), n);
    end
  endtask

  task automatic test_back_to_back();
    bit [63:0] got, exp, one;
    int        len, accepts;
    bit        prev_busy;
    got       = '0;
    accepts   = 0;
    prev_busy = 1'b0;
    len       = model(8'h05, one);
    exp       = one | (one << (len + 1));
    @(negedge clk);
    din       = 8'h05;
    din_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      got[c] = seq_out;
      if (busy && !prev_busy) accepts++;
      prev_busy = busy;
      if (accepts == 2) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    n_cmp++;
    if (accepts != 2) begin
      n_bad++;
      $display("FAIL b2b accepts got=%0d want=2", accepts);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL b2b line got=%h want=%h", got, exp);
    end
    n_cmp++;
    if (det_mask(got, 40) !== det_mask(exp, 40)) begin
      n_bad++;
      $display("FAIL b2b detector got=%h want=%h", det_mask(got, 40), det_mask(exp, 40));
    end
`ifdef SD_FRAMER_TX_STUFF_EN
    n_cmp++;
    if (det_mask(got, 40) !== ((64'h1 << 3) | (64'h1 << (len + 4)))) begin
      n_bad++;
      $display("FAIL b2b preamble_only got=%h", det_mask(got, 40));
    end
`endif
  endtask

  task automatic test_reset_midframe();
    int n;
    @(negedge clk);
    din       = 8'($urandom);
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (seq_out !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || state_out !== 2'd0) begin
      n_bad++;
      $display("FAIL midreset got seq_out=%b busy=%b din_ready=%b state=%0d want 0/0/1/0",
               seq_out, busy, din_ready, state_out);
    end
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'hFF, "after_reset_ff", n);
    n_cmp++;
    if (n != 12) begin
      n_bad++;
      $display("FAIL after_reset_len got=%0d want=12", n);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
